// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I widths, constants and fetch entry type
package rv32i_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_INC        = 32'd4;
   localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef logic [XLEN-1:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry FIFO holding fetched {pc, instr} pairs
module fetch_fifo #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == 2'd2);
   assign empty = (count_q == 2'd0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // A full FIFO still accepts a push when the head leaves in the same cycle.
      do_push  = push && (!full || pop);
      do_pop   = pop && !empty;
      if (flush) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - credit-limited instruction fetch with redirect and stale-response discard
module fetch_stage
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D
);

   word_t        pc_q, pc_d;
   logic [1:0]   out_q, out_d;
   logic [1:0]   discard_q, discard_d;
   logic [1:0]   discard_after;
   // Issued PCs of granted-but-unanswered requests, matched to responses in order.
   word_t        ifq_q [2];
   word_t        ifq_d [2];
   logic         ifq_wr_q, ifq_wr_d;
   logic         ifq_rd_q, ifq_rd_d;

   logic         grant;
   logic [2:0]   used;
   logic         fifo_push, fifo_pop;
   logic         fifo_full, fifo_empty;
   logic [1:0]   fifo_count;
   fetch_entry_t push_entry;
   fetch_entry_t head;

   assign imem_addr = pc_q;

   always_comb begin
      used      = {1'b0, out_q} + {1'b0, fifo_count};
      imem_req  = rst && !redirect && !fifo_full && (used < 3'(DEPTH));
      grant     = imem_req && imem_gnt;

      pc_d      = pc_q;
      ifq_d     = ifq_q;
      ifq_wr_d  = ifq_wr_q;
      ifq_rd_d  = ifq_rd_q;

      if (redirect) begin
         pc_d = redirect_pc & PC_ALIGN_MASK;
      end else if (grant) begin
         pc_d = pc_q + PC_INC;
      end

      if (grant) begin
         ifq_d[ifq_wr_q] = pc_q;
         ifq_wr_d        = ~ifq_wr_q;
      end
      if (imem_rvalid) begin
         ifq_rd_d = ~ifq_rd_q;
      end

      out_d         = out_q + {1'b0, grant} - {1'b0, imem_rvalid};
      discard_after = (imem_rvalid && (discard_q != 2'd0)) ? discard_q - 2'd1 : discard_q;
      // Everything still in flight after a redirect is stale, whether or not it was already marked.
      discard_d     = redirect ? out_d : discard_after;

      fifo_push        = imem_rvalid && (discard_q == 2'd0) && !redirect;
      fifo_pop         = id_valid && id_ready && !redirect;
      push_entry.pc    = ifq_q[ifq_rd_q];
      push_entry.instr = imem_rdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q      <= RESET_PC;
         out_q     <= 2'd0;
         discard_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            ifq_q[i] <= '0;
         end
         ifq_wr_q  <= 1'b0;
         ifq_rd_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         out_q     <= out_d;
         discard_q <= discard_d;
         ifq_q     <= ifq_d;
         ifq_wr_q  <= ifq_wr_d;
         ifq_rd_q  <= ifq_rd_d;
      end
   end

   fetch_fifo #(
      .WIDTH (2 * XLEN)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (redirect),
      .wdata (push_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      id_valid = !fifo_empty;
      InstrD   = NOP_INSTR;
      PCD      = '0;
      PCPlus4D = '0;
      if (!fifo_empty) begin
         InstrD   = head.instr;
         PCD      = head.pc;
         PCPlus4D = head.pc + PC_INC;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] I0    = 32'h00A0_0093;
   localparam logic [31:0] I1    = 32'h0010_8113;
   localparam logic [31:0] I2    = 32'h0021_0193;
   localparam logic [31:0] I3    = 32'h0031_8213;
   localparam logic [31:0] STALE = 32'hDEAD_BEEF;
   localparam logic [31:0] I100  = 32'h1000_0113;
   localparam logic [31:0] I104  = 32'h1040_0193;
   localparam logic [31:0] I108  = 32'h1080_0213;
   localparam logic [31:0] IW    = 32'hFFC0_0093;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] PCPlus4D;

   int total = 0;
   int bad   = 0;

   fetch_stage #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .InstrD      (InstrD),
      .PCD         (PCD),
      .PCPlus4D    (PCPlus4D)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                        input logic rdr, input logic [31:0] rpc, input logic rdy);
      imem_gnt    = g;
      imem_rvalid = rv;
      imem_rdata  = rd;
      redirect    = rdr;
      redirect_pc = rpc;
      id_ready    = rdy;
      #1;
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #10;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_idv", {31'd0, id_valid}, 32'd0);
      chk("rst_instr", InstrD, NOP);
      chk("rst_pcd", PCD, 32'h0);
      chk("rst_addr", imem_addr, 32'h0);

      tick(); rst = 1'b1; drive(1, 0, 0, 0, 0, 1);
      chk("c0_req", {31'd0, imem_req}, 32'd1);
      chk("c0_addr", imem_addr, 32'h0);

      tick(); drive(1, 1, I0, 0, 0, 1);
      chk("c1_addr", imem_addr, 32'h4);
      chk("c1_idv", {31'd0, id_valid}, 32'd0);

      tick(); drive(0, 1, I1, 0, 0, 1);
      chk("c2_idv", {31'd0, id_valid}, 32'd1);
      chk("c2_instr", InstrD, I0);
      chk("c2_pcd", PCD, 32'h0);
      chk("c2_pc4", PCPlus4D, 32'h4);
      chk("c2_req", {31'd0, imem_req}, 32'd0);

      tick(); drive(0, 0, 0, 0, 0, 1);
      chk("c3_instr", InstrD, I1);
      chk("c3_pcd", PCD, 32'h4);
      chk("c3_pc4", PCPlus4D, 32'h8);
      chk("c3_addr", imem_addr, 32'h8);
      chk("c3_req", {31'd0, imem_req}, 32'd1);

      for (int i = 0; i < 2; i++) begin
         tick(); drive(0, 0, 0, 0, 0, 1);
         chk("nognt_addr", imem_addr, 32'h8);
         chk("nognt_req", {31'd0, imem_req}, 32'd1);
      end

      tick(); drive(1, 0, 0, 0, 0, 1);
      chk("c6_addr", imem_addr, 32'h8);
      tick(); drive(1, 1, I2, 0, 0, 0);
      chk("c7_addr", imem_addr, 32'hC);
      chk("c7_req", {31'd0, imem_req}, 32'd1);

      tick(); drive(0, 1, I3, 0, 0, 0);
      chk("c8_req", {31'd0, imem_req}, 32'd0);
      chk("c8_pcd", PCD, 32'h8);

      for (int i = 0; i < 3; i++) begin
         tick(); drive(0, 0, 0, 0, 0, 0);
         chk("stall_req", {31'd0, imem_req}, 32'd0);
         chk("stall_pcd", PCD, 32'h8);
         chk("stall_idv", {31'd0, id_valid}, 32'd1);
      end

      tick(); drive(0, 0, 0, 0, 0, 1);
      chk("c12_instr", InstrD, I2);
      chk("c12_pcd", PCD, 32'h8);
      tick(); drive(1, 0, 0, 0, 0, 1);
      chk("c13_instr", InstrD, I3);
      chk("c13_pcd", PCD, 32'hC);
      chk("c13_pc4", PCPlus4D, 32'h10);
      chk("c13_addr", imem_addr, 32'h10);

      tick(); drive(0, 0, 0, 1, 32'h0000_0103, 1);
      chk("c14_req", {31'd0, imem_req}, 32'd0);
      tick(); drive(1, 1, STALE, 0, 0, 1);
      chk("c15_addr", imem_addr, 32'h100);
      chk("c15_req", {31'd0, imem_req}, 32'd1);
      chk("c15_idv", {31'd0, id_valid}, 32'd0);
      tick(); drive(0, 1, I100, 0, 0, 1);
      chk("c16_idv", {31'd0, id_valid}, 32'd0);
      chk("c16_addr", imem_addr, 32'h104);
      tick(); drive(1, 0, 0, 0, 0, 1);
      chk("c17_idv", {31'd0, id_valid}, 32'd1);
      chk("c17_pcd", PCD, 32'h100);
      chk("c17_instr", InstrD, I100);
      chk("c17_pc4", PCPlus4D, 32'h104);

      tick(); drive(1, 1, I104, 0, 0, 1);
      chk("c18_addr", imem_addr, 32'h108);
      tick(); drive(0, 1, I108, 1, 32'h0000_0200, 1);
      chk("c19_pcd", PCD, 32'h104);
      chk("c19_req", {31'd0, imem_req}, 32'd0);
      tick(); drive(0, 0, 0, 0, 0, 1);
      chk("c20_idv", {31'd0, id_valid}, 32'd0);
      chk("c20_instr", InstrD, NOP);
      chk("c20_pcd", PCD, 32'h0);
      chk("c20_addr", imem_addr, 32'h200);
      chk("c20_req", {31'd0, imem_req}, 32'd1);

      tick(); drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0);
      tick(); drive(1, 0, 0, 0, 0, 0);
      chk("c22_addr", imem_addr, 32'hFFFF_FFFC);
      tick(); drive(1, 0, 0, 0, 0, 0);
      chk("wrap_addr", imem_addr, 32'h0);
      tick(); drive(0, 1, IW, 0, 0, 0);
      chk("c24_req", {31'd0, imem_req}, 32'd0);
      chk("c24_addr", imem_addr, 32'h4);
      tick(); drive(0, 0, 0, 0, 0, 0);
      chk("c25_pcd", PCD, 32'hFFFF_FFFC);
      chk("c25_pc4", PCPlus4D, 32'h0);
      chk("c25_instr", InstrD, IW);

      #1; rst = 1'b0; #1;
      chk("arst_req", {31'd0, imem_req}, 32'd0);
      chk("arst_idv", {31'd0, id_valid}, 32'd0);
      chk("arst_instr", InstrD, NOP);
      chk("arst_pcd", PCD, 32'h0);
      chk("arst_addr", imem_addr, 32'h0);

      tick(); rst = 1'b1; drive(0, 0, 0, 0, 0, 0);
      chk("rel_req", {31'd0, imem_req}, 32'd1);
      chk("rel_addr", imem_addr, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
